// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder sequencer: FSM states, load modes
// and the legal parameter ranges.
package decoder_pkg;

    localparam int SEL_W_MIN     = 1;
    localparam int SEL_W_MAX     = 6;
    localparam int PULSE_CYC_MIN = 1;
    localparam int PULSE_CYC_MAX = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEVEL = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'd0,
        MODE_PULSE = 2'd1,
        MODE_SCAN  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    // Bits needed to hold a count in the range 0..n
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with an enable; all-zero when disabled.
module onehot_dec #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic [SEL_W-1:0] a,
    input  logic             en,
    output logic [OUT_W-1:0] y
);

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign y[gi] = en && (a == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_seq.sv
// One-hot decoder sequencer: holds a level, emits a timed strobe, or rotates a
// single bit through every output position, with busy/done handshaking.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter  int SEL_W     = 3,
    parameter  int PULSE_CYC = 1,
    localparam int OUT_W     = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] a,
    input  logic             load,
    output logic [OUT_W-1:0] y,
    output logic             busy,
    output logic             done
);

    localparam int PCNT_W = cnt_width(PULSE_CYC);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_CYC - 1);
    localparam logic [SEL_W-1:0]  SCAN_LAST  = SEL_W'(OUT_W - 1);

    state_t             state_reg, state_next;
    logic [OUT_W-1:0]   y_reg, y_next;
    logic [PCNT_W-1:0]  pcnt_reg, pcnt_next;
    logic [SEL_W-1:0]   scnt_reg, scnt_next;
    logic               done_reg, done_next;
    logic [OUT_W-1:0]   dec_y;
    logic               accept;

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .a  (a),
        .en (1'b1),
        .y  (dec_y)
    );

    // busy comes straight from the state register, so it is low in the done cycle
    assign busy   = (state_reg == ST_PULSE) || (state_reg == ST_SCAN);
    assign accept = load && en && !busy;

    assign y    = y_reg;
    assign done = done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            y_reg     <= '0;
            pcnt_reg  <= '0;
            scnt_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            pcnt_reg  <= pcnt_next;
            scnt_reg  <= scnt_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        pcnt_next  = pcnt_reg;
        scnt_next  = scnt_reg;
        done_next  = 1'b0;

        if (!en) begin
            state_next = ST_IDLE;
            y_next     = '0;
            pcnt_next  = '0;
            scnt_next  = '0;
        end else if (accept) begin
            y_next = dec_y;
            case (mode_t'(mode))
                MODE_PULSE: begin
                    state_next = ST_PULSE;
                    pcnt_next  = PULSE_LAST;
                end
                MODE_SCAN: begin
                    state_next = ST_SCAN;
                    scnt_next  = SCAN_LAST;
                end
                default: state_next = ST_LEVEL;
            endcase
        end else begin
            // Counters hold the number of further cycles still to present
            case (state_reg)
                ST_PULSE: begin
                    if (pcnt_reg == '0) begin
                        state_next = ST_IDLE;
                        y_next     = '0;
                        done_next  = 1'b1;
                    end else begin
                        pcnt_next = pcnt_reg - PCNT_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (scnt_reg == '0) begin
                        state_next = ST_IDLE;
                        y_next     = '0;
                        done_next  = 1'b1;
                    end else begin
                        y_next    = {y_reg[OUT_W-2:0], y_reg[OUT_W-1]};
                        scnt_next = scnt_reg - SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Randomised bench for decoder_seq at three parameter points, checked every cycle
// against a queue-of-expected-outputs model, plus directed literal checks.
module tb_decoder_seq;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [5:0]  a_in = 6'd0;
    logic        load = 1'b0;

    logic [7:0]  y0;
    logic [1:0]  y1;
    logic [63:0] y2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;

    always #5 clk = ~clk;

    decoder_seq #(.SEL_W(3), .PULSE_CYC(3)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a_in[2:0]), .load(load),
        .y(y0), .busy(busy0), .done(done0)
    );
    decoder_seq #(.SEL_W(1), .PULSE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a_in[0:0]), .load(load),
        .y(y1), .busy(busy1), .done(done1)
    );
    decoder_seq #(.SEL_W(6), .PULSE_CYC(255)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a_in[5:0]), .load(load),
        .y(y2), .busy(busy2), .done(done2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    function automatic int sw_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            default: return 6;
        endcase
    endfunction

    function automatic int pc_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            default: return 255;
        endcase
    endfunction

    // Model: an accepted PULSE/SCAN load lays out its whole output sequence;
    // each cycle consumes one entry. LEVEL simply remembers a held value.
    logic [63:0] seq_y [NI][256];
    int          seq_len [NI];
    int          seq_pos [NI];
    bit          lvl_on [NI];
    logic [63:0] lvl_y [NI];
    bit          done_m [NI];
    int          m_ow;
    int          m_idx;

    initial begin
        for (int k = 0; k < NI; k++) begin
            seq_len[k] = 0; seq_pos[k] = 0; lvl_on[k] = 0; lvl_y[k] = '0; done_m[k] = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            m_ow = 1 << sw_of(k);
            if (rst || !en) begin
                seq_len[k] = 0; seq_pos[k] = 0; lvl_on[k] = 0; done_m[k] = 0;
            end else begin
                done_m[k] = 0;
                if (seq_pos[k] < seq_len[k]) begin
                    seq_pos[k]++;
                    if (seq_pos[k] == seq_len[k]) done_m[k] = 1;
                end else if (load) begin
                    m_idx = int'(a_in) % m_ow;
                    lvl_on[k] = 0; seq_pos[k] = 0; seq_len[k] = 0;
                    if (mode == 2'd1) begin
                        for (int i = 0; i < pc_of(k); i++) seq_y[k][i] = 64'd1 << m_idx;
                        seq_len[k] = pc_of(k);
                    end else if (mode == 2'd2) begin
                        for (int i = 0; i < m_ow; i++) seq_y[k][i] = 64'd1 << ((m_idx + i) % m_ow);
                        seq_len[k] = m_ow;
                    end else begin
                        lvl_on[k] = 1;
                        lvl_y[k]  = 64'd1 << m_idx;
                    end
                end
            end
        end
    end

    function automatic logic [65:0] dut_out(input int k);
        case (k)
            0:       return {busy0, done0, 56'd0, y0};
            1:       return {busy1, done1, 62'd0, y1};
            default: return {busy2, done2, y2};
        endcase
    endfunction

    function automatic logic [65:0] model_out(input int k);
        logic [63:0] ey;
        bit run;
        run = seq_pos[k] < seq_len[k];
        if (run)            ey = seq_y[k][seq_pos[k]];
        else if (lvl_on[k]) ey = lvl_y[k];
        else                ey = '0;
        return {run, run ? 1'b0 : done_m[k], ey};
    endfunction

    // Per-cycle comparison against the model for every instance
    always @(negedge clk) begin
        if (checking && !rst) begin
            for (int k = 0; k < NI; k++) begin
                logic [65:0] got, exp;
                got = dut_out(k);
                exp = model_out(k);
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL model_cmp dut%0d t=%0t: got busy=%b done=%b y=%h, expected busy=%b done=%b y=%h",
                             k, $time, got[65], got[64], got[63:0], exp[65], exp[64], exp[63:0]);
                end
                n_cmp++;
                if ($countones(got[63:0]) > 1) begin
                    n_bad++;
                    $display("FAIL onehot dut%0d t=%0t: y=%h has %0d bits set, expected at most 1",
                             k, $time, got[63:0], $countones(got[63:0]));
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk0(input string nm, input logic [7:0] ey, input logic eb, input logic ed);
        chk({nm, ".y"},    {56'd0, y0},    {56'd0, ey});
        chk({nm, ".busy"}, {63'd0, busy0}, {63'd0, eb});
        chk({nm, ".done"}, {63'd0, done0}, {63'd0, ed});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [7:0] scan_exp [8];

    initial begin
        scan_exp[0] = 8'h40; scan_exp[1] = 8'h80; scan_exp[2] = 8'h01; scan_exp[3] = 8'h02;
        scan_exp[4] = 8'h04; scan_exp[5] = 8'h08; scan_exp[6] = 8'h10; scan_exp[7] = 8'h20;

        repeat (3) tick();
        chk0("reset", 8'h00, 1'b0, 1'b0);
        chk("reset.y2", y2, 64'd0);
        rst = 1'b0;
        checking = 1'b1;
        tick();

        $display("txn: LEVEL a=5");
        en = 1'b1; load = 1'b1; mode = 2'd0; a_in = 6'd5;
        tick();
        chk0("level_a5", 8'h20, 1'b0, 1'b0);
        $display("txn: LEVEL a=2");
        a_in = 6'd2;
        tick();
        chk0("level_a2", 8'h04, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk0("level_hold", 8'h04, 1'b0, 1'b0);

        $display("txn: PULSE a=1");
        load = 1'b1; mode = 2'd1; a_in = 6'd1;
        tick();
        chk0("pulse_c1", 8'h02, 1'b1, 1'b0);
        mode = 2'd2; a_in = 6'd7;
        tick();
        chk0("pulse_c2", 8'h02, 1'b1, 1'b0);
        tick();
        chk0("pulse_c3", 8'h02, 1'b1, 1'b0);
        load = 1'b0;
        tick();
        chk0("pulse_done", 8'h00, 1'b0, 1'b1);
        tick();
        chk0("pulse_after", 8'h00, 1'b0, 1'b0);

        $display("txn: SCAN a=6");
        load = 1'b1; mode = 2'd2; a_in = 6'd6;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk0($sformatf("scan6_p%0d", i), scan_exp[i], 1'b1, 1'b0);
            load = 1'b0;
        end
        tick();
        chk0("scan6_done", 8'h00, 1'b0, 1'b1);
        $display("txn: LEVEL a=3 in done cycle");
        load = 1'b1; mode = 2'd0; a_in = 6'd3;
        tick();
        chk0("b2b_level", 8'h08, 1'b0, 1'b0);
        load = 1'b0;

        $display("txn: SCAN a=0 with abort");
        load = 1'b1; mode = 2'd2; a_in = 6'd0;
        tick();
        chk0("scan0_p0", 8'h01, 1'b1, 1'b0);
        load = 1'b0;
        tick();
        chk0("scan0_p1", 8'h02, 1'b1, 1'b0);
        tick();
        chk0("scan0_p2", 8'h04, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        chk0("abort", 8'h00, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        chk0("abort_nodone", 8'h00, 1'b0, 1'b0);

        $display("txn: PULSE a=4 with async reset");
        load = 1'b1; mode = 2'd1; a_in = 6'd4;
        tick();
        chk0("pulse4_c1", 8'h10, 1'b1, 1'b0);
        load = 1'b0;
        #2 rst = 1'b1;
        #1 chk0("async_rst", 8'h00, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick();
        chk0("post_rst", 8'h00, 1'b0, 1'b0);
        tick();
        chk0("post_rst_nodone", 8'h00, 1'b0, 1'b0);

        $display("txn: random phase");
        for (int c = 0; c < 6000; c++) begin
            en   = ($urandom_range(0, 199) != 0);
            load = ($urandom_range(0, 2) == 0);
            mode = 2'($urandom_range(0, 3));
            a_in = 6'($urandom);
            tick();
        end

        checking = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter SEL_W, default 3: select width; legal range 1..6.
REQ-002 Parameter PULSE_CYC, default 1: strobe length in cycles for PULSE mode; legal range 1..255.
REQ-003 Derived constant OUT_W = 2**SEL_W: output one-hot width; not overridable.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  global enable; low forces block idle.
REQ-007 mode  in  2  0=LEVEL, 1=PULSE, 2=SCAN, 3=reserved (treated as LEVEL).
REQ-008 a  in  SEL_W  select / scan start index.
REQ-009 load  in  1  request to accept a and mode.
REQ-010 y  out  OUT_W  registered one-hot (or all-zero) output.
REQ-011 busy  out  1  high while a PULSE or SCAN sequence is running; load ignored.
REQ-012 done  out  1  one-cycle pulse on normal completion of PULSE or SCAN.

Function
REQ-013 Accept condition: load=1 and en=1 and busy=0 at a rising edge; mode and a sampled only on acceptance.
REQ-014 States: IDLE, LEVEL, PULSE, SCAN; encoding in shared package.
REQ-015 Latency: y reflects an accepted load on the next cycle (1-cycle registered).
REQ-016 LEVEL: y = one-hot(a), held until next accepted load or en=0; busy stays 0; new load in LEVEL replaces y next cycle.
REQ-017 PULSE: y = one-hot(a) for exactly PULSE_CYC cycles, then y=0, state IDLE; busy=1 during those cycles; done=1 for one cycle in the first cycle y=0.
REQ-018 SCAN: y = one-hot(a), then shifts one bit up per cycle, wrapping bit OUT_W-1 to bit 0, visiting all OUT_W positions exactly once; final position is index (a-1) mod OUT_W; next cycle y=0, done=1, state IDLE.
REQ-019 busy=1 in every cycle of PULSE/SCAN where y is non-zero; busy=0 in the done cycle, so a load in the done cycle is accepted.
REQ-020 y is never multi-hot; at most one bit set in any cycle.
REQ-021 en=0 at a rising edge: next cycle y=0, busy=0, state IDLE, done=0 (abort is not completion).
REQ-022 load while busy=1: ignored, no queueing, sequence continues unchanged.
REQ-023 Simultaneous en=0 and load=1: en wins, block idles.
REQ-024 SEL_W=1 SCAN: two positions then done; PULSE_CYC=1: single-cycle strobe.
REQ-025 Pulse counter width ceil(log2(PULSE_CYC+1)); scan counter width SEL_W; no overflow at parameter limits.

Reset
REQ-026 rst high: immediately (asynchronously) y=0, busy=0, done=0, state IDLE, counters 0.
REQ-027 rst asserted mid-sequence aborts it without done; first accept possible on the first edge after rst deasserts.

Structure
REQ-028 Shared package decoder_pkg holds state enum, mode enum (MODE_LEVEL/PULSE/SCAN) and legal-range constants for SEL_W and PULSE_CYC.
REQ-029 One combinational sub-module onehot_dec (parametrised SEL_W, en input, OUT_W output) generates one-hot(a); decoder_seq instantiates it for load decode.
REQ-030 Scan shifting is a rotate of the y register, not a re-decode.

Verification
REQ-031 SEL_W=3, LEVEL, a=5 load -> next cycle y=0x20, busy=0, done=0; later load a=2 -> y=0x04 next cycle.
REQ-032 SEL_W=3, PULSE_CYC=3, PULSE a=1 -> y=0x02 for 3 cycles, busy=1, then y=0 with done=1 one cycle; load asserted during busy ignored.
REQ-033 SEL_W=3, SCAN a=6 -> y sequence 0x40,0x80,0x01,0x02,0x04,0x08,0x10,0x20, then y=0 with done=1; back-to-back load in done cycle accepted.
REQ-034 SCAN a=0, en dropped after 3rd position -> next cycle y=0, busy=0, done never asserted.
REQ-035 rst pulsed asynchronously mid-PULSE (between edges) -> y=0, busy=0 immediately; no done after release.
REQ-036 SEL_W=1 and SEL_W=6 sweeps: every a in all modes -> y always one-hot or zero, SCAN length equals OUT_W.
